// File: rtl/vector_rev_arb.sv
// Two-requester round-robin front end sharing one W-bit bit-reverser, with a
// single-entry registered output stage that supports pop-and-load in one cycle.
module vector_rev_arb #(
    parameter int W = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic           last_grant;
    logic           space;
    logic           grant0;
    logic           grant1;
    logic           take;
    logic [W-1:0]   sel_data;
    logic [W-1:0]   rev_data;

    assign out_valid = (state == FULL);
    assign space     = !out_valid || out_ready;

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    // Ready is gated by rst so a requester never sees a handshake that reset discards.
    assign req0_ready = !rst && space && grant0;
    assign req1_ready = !rst && space && grant1;
    assign take       = req0_ready || req1_ready;

    assign sel_data = req1_ready ? req1_data : req0_data;

    always_comb begin
        // NOTE: default assignment first so every path drives rev_data and no latch is inferred.
        rev_data = '0;
        for (int i = 0; i < W; i++) begin
            rev_data[i] = sel_data[W-1-i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (take) begin
                        state      <= FULL;
                        out_data   <= rev_data;
                        out_src    <= req1_ready;
                        last_grant <= req1_ready;
                    end
                end
                FULL: begin
                    if (take) begin
                        out_data   <= rev_data;
                        out_src    <= req1_ready;
                        last_grant <= req1_ready;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_rev_arb.sv
// Randomized and directed bench for vector_rev_arb: a queue-based scoreboard fed by
// an abstract arbitration model, drained by an independent output monitor.
module tb_vector_rev_arb;

    localparam int W = 100;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    vector_rev_arb #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         src;
        logic [W-1:0] data;
    } item_t;

    item_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    // Model state: whether a result is held, and who was served last.
    logic  m_valid = 1'b0;
    logic  m_last  = 1'b1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [W-1:0] reverse(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = {<<{d}};
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic drive(input logic r, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic ordy);
        rst        = r;
        req0_valid = v0;
        req0_data  = v0 ? d0 : 'x;
        req1_valid = v1;
        req1_data  = v1 ? d1 : 'x;
        out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model side: predict handshakes and enqueue expected results.
    initial begin
        logic space, g0, g1;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("ready_in_reset", W'({req0_ready, req1_ready}), W'(2'b00));
                m_valid = 1'b0;
                m_last  = 1'b1;
                sb.delete();
            end else begin
                space = !m_valid || out_ready;
                g0 = space && req0_valid && (!req1_valid || m_last == 1'b1);
                g1 = space && req1_valid && !g0;
                check("out_valid", W'(out_valid), W'(m_valid));
                check("ready", W'({req0_ready, req1_ready}), W'({g0, g1}));
                if (g0) begin
                    sb.push_back('{src: 1'b0, data: reverse(req0_data)});
                    m_last = 1'b0;
                end else if (g1) begin
                    sb.push_back('{src: 1'b1, data: reverse(req1_data)});
                    m_last = 1'b1;
                end
                if (g0 || g1) m_valid = 1'b1;
                else if (m_valid && out_ready) m_valid = 1'b0;
            end
        end
    end

    // Output monitor: whatever the DUT presents must match the oldest accepted vector.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", W'(1), W'(0));
                end else begin
                    check("out_src", W'(out_src), W'(sb[0].src));
                    check("out_data", out_data, sb[0].data);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] held, d0, d1;
        logic [W-1:0] one;
        one = W'(1);

        // Reset state
        drive(1, 0, '0, 0, '0, 0);
        tick();
        tick();
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_src", W'(out_src), W'(0));

        // Single vector from requester 0, one-cycle latency
        drive(0, 1, one, 0, '0, 1);
        tick();
        check("first_valid", W'(out_valid), W'(1));
        check("first_data", out_data, one << (W - 1));
        check("first_src", W'(out_src), W'(0));

        // Both valid from reset: strict alternation starting at requester 0
        drive(1, 0, '0, 0, '0, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, rand_vec(), 1, rand_vec(), 1);
            tick();
            check("alt_valid", W'(out_valid), W'(1));
            check("alt_src", W'(out_src), W'(k % 2));
        end

        // Stall for five cycles with both requesters waiting
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, rand_vec(), 1, rand_vec(), 0);
            tick();
            check("stall_data", out_data, held);
            check("stall_ready", W'({req0_ready, req1_ready}), W'(2'b00));
        end
        d0 = rand_vec();
        d1 = rand_vec();
        drive(0, 1, d0, 1, d1, 1);
        #1;
        check("release_ready", W'({req0_ready, req1_ready}), W'(2'b10));
        tick();
        check("release_src", W'(out_src), W'(0));
        check("release_data", out_data, reverse(d0));

        // Requester 1 alone: 0x3, 0x5, 0x6
        drive(0, 0, '0, 1, W'(3), 1);
        tick();
        check("r1_src_a", W'(out_src), W'(1));
        check("r1_data_a", out_data, W'(3) << (W - 2));
        drive(0, 0, '0, 1, W'(5), 1);
        tick();
        check("r1_src_b", W'(out_src), W'(1));
        check("r1_data_b", out_data, (one << (W - 1)) | (one << (W - 3)));
        drive(0, 0, '0, 1, W'(6), 1);
        tick();
        check("r1_src_c", W'(out_src), W'(1));
        check("r1_data_c", out_data, W'(3) << (W - 3));

        // Reset with a pending result and both requesters valid
        drive(0, 1, rand_vec(), 1, rand_vec(), 0);
        tick();
        drive(1, 1, rand_vec(), 1, rand_vec(), 1);
        tick();
        check("rst_mid_valid", W'(out_valid), W'(0));
        check("rst_mid_data", out_data, '0);
        d0 = rand_vec();
        drive(0, 1, d0, 1, rand_vec(), 1);
        tick();
        check("post_rst_src", W'(out_src), W'(0));
        check("post_rst_data", out_data, reverse(d0));

        // Random traffic
        for (int k = 0; k < 1000; k++) begin
            drive(0, 1'($urandom_range(0, 1)), rand_vec(), 1'($urandom_range(0, 1)),
                  rand_vec(), 1'($urandom_range(0, 3) != 0));
            tick();
        end

        // Drain and confirm every accepted vector came out
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, '0, 0, '0, 1);
            tick();
        end
        check("sb_drained", W'(sb.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vector_rev_arb.md
VECTOR_REV_ARB -- requirements
Module: vector_rev_arb

Interface
REQ-001 Parameter: W, default 100, data vector width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 Port: req0_valid  input  1  requester 0 has a vector to reverse.
REQ-005 Port: req0_data  input  W  requester 0 vector.
REQ-006 Port: req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has a vector to reverse.
REQ-008 Port: req1_data  input  W  requester 1 vector.
REQ-009 Port: req1_ready  output  1  requester 1 transfer accepted this cycle.
REQ-010 Port: out_valid  output  1  out_data/out_src hold a result.
REQ-011 Port: out_data  output  W  bit-reversed vector.
REQ-012 Port: out_src  output  1  requester index the result belongs to.
REQ-013 Port: out_ready  input  1  consumer accepts result this cycle.

Function
REQ-014 Block SHALL share one W-bit reverser between two requesters: out_data[i] = captured_data[W-1-i] for all i in 0..W-1.
REQ-015 Transfer on requester n SHALL occur when reqn_valid && reqn_ready on a rising edge; output pop SHALL occur when out_valid && out_ready.
REQ-016 Output stage SHALL be a single-entry register; "space" = !out_valid || out_ready (combinational).
REQ-017 Arbitration SHALL be round-robin with a 1-bit last_grant register: only one valid -> that one granted; both valid -> the requester != last_grant granted.
REQ-018 reqn_ready SHALL be 1 only when space && reqn_valid && requester n granted; req0_ready and req1_ready SHALL never both be 1.
REQ-019 reqn_ready SHALL depend combinationally on reqn_valid, the other valid, out_valid, out_ready, last_grant only (no path from data inputs).
REQ-020 On a transfer from n: next cycle out_valid=1, out_data=reverse(reqn_data), out_src=n, last_grant=n; latency accept-to-out_valid = 1 cycle.
REQ-021 Pop with no simultaneous transfer SHALL clear out_valid next cycle; out_data/out_src SHALL keep previous values.
REQ-022 Simultaneous pop and transfer SHALL load the new result, out_valid stays 1; sustained throughput = 1 vector/cycle.
REQ-023 While out_valid && !out_ready, out_data, out_src, out_valid SHALL hold stable and both reqn_ready SHALL be 0.
REQ-024 last_grant SHALL change only on a transfer; a granted-but-stalled requester keeps its grant next cycle.
REQ-025 reqn_data SHALL be ignored when no transfer on n occurs; X on unused data SHALL not propagate to out_data.
REQ-026 FSM: EMPTY (out_valid=0) -> FULL on transfer; FULL -> EMPTY on pop without transfer; FULL -> FULL on pop+transfer or stall.

Reset
REQ-027 While rst=1 at a rising edge: out_valid=0, out_data=0, out_src=0, last_grant=1 (so requester 0 wins the first tie).
REQ-028 rst SHALL override any concurrent transfer or pop; an in-flight result SHALL be discarded, no reqn_ready asserted in the reset cycle's effect.
REQ-029 First cycle after rst deasserts, block SHALL be in EMPTY and accept a transfer immediately.

Verification
REQ-030 Reset, then req0_valid=1, req0_data=1, out_ready=1 one cycle -> next cycle out_valid=1, out_data=1<<99, out_src=0.
REQ-031 Both valid every cycle, out_ready=1, from reset -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1 with out_valid continuously 1.
REQ-032 Result pending, out_ready=0 for 5 cycles with both valid -> out_data stable, req0_ready=req1_ready=0; on out_ready=1, pop and new transfer same cycle.
REQ-033 Only req1 valid for 3 transfers (data 0x3, 0x5, 0x6) -> out_src=1 each, out_data = reversed values (bits 99:98=11, 99/97 set, 98:97=11).
REQ-034 rst asserted while out_valid=1 and both valid -> next cycle out_valid=0, out_data=0; first tie afterwards granted to requester 0.
REQ-035 Random stimulus, 1000 cycles, random valid/ready -> scoreboard: every accepted vector appears once, reversed, in acceptance order, with correct out_src.
